ahblite_apb_bridge: RTL

//  AHB-Lite slave to APB4 master bridge. Sits downstream of one slave port of the AHB-Lite

---
 rtl/ahb_apb_pkg.sv | 39 +++
 rtl/ahblite_apb_bridge_if.sv | 46 ++++
 rtl/ahblite_apb_bridge.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types and helpers for the AHB-Lite to APB4 bridge.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } bridge_state_e;

  // Byte lanes touched by a write; reads never drive strobes.
  function automatic logic [3:0] apb_strb(input logic [2:0] hsize,
                                          input logic [1:0] addr,
                                          input logic       write);
    logic [3:0] strb;
    strb = 4'h0;
    if (write) begin
      case (hsize)
        HSIZE_BYTE: strb = 4'b0001 << addr;
        HSIZE_HALF: strb = 4'b0011 << {addr[1], 1'b0};
        default:    strb = 4'hF;
      endcase
    end
    return strb;
  endfunction

endpackage

// File: rtl/ahblite_apb_bridge_if.sv
// AHB-Lite slave port and APB4 master port of the bridge, bundled.
interface ahblite_apb_bridge_if #(
  parameter int unsigned AHB_AW = 32,
  parameter int unsigned AHB_DW = 32,
  parameter int unsigned APB_AW = 16
);
  logic              hready;
  logic              hsel;
  logic [AHB_AW-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic [AHB_DW-1:0] hwdata;
  logic              hmastlock;
  logic              hreadyout;
  logic              hresp;
  logic [AHB_DW-1:0] hrdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [APB_AW-1:0] paddr;
  logic [AHB_DW-1:0] pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [AHB_DW-1:0] prdata;
  logic              pready;
  logic              pslverr;

  // Bridge view: AHB slave inputs plus APB completer responses in.
  modport slave (
    input  hready, hsel, haddr, hwrite, htrans, hsize, hburst, hprot, hwdata, hmastlock,
    input  prdata, pready, pslverr,
    output hreadyout, hresp, hrdata,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

  // Environment view: AHB master and APB completer.
  modport master (
    output hready, hsel, haddr, hwrite, htrans, hsize, hburst, hprot, hwdata, hmastlock,
    output prdata, pready, pslverr,
    input  hreadyout, hresp, hrdata,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/ahblite_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB SETUP+ACCESS per NONSEQ/SEQ beat.
// Optional: define AHB_APB_BRIDGE_PSLVERR_EN to turn PSLVERR into a two-cycle AHB ERROR.
module ahblite_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int unsigned AHB_AW = 32,
  parameter int unsigned AHB_DW = 32,
  parameter int unsigned APB_AW = 16
) (
  input logic                 clk,
  input logic                 rst,
  ahblite_apb_bridge_if.slave bus
);

  bridge_state_e     state_q, state_d;
  logic              accept_c, done_c, err_c;
  logic              psel_d, penable_d, hreadyout_d;
  logic              psel_q, penable_q, hreadyout_q, pwrite_q;
  logic [APB_AW-1:0] paddr_q;
  logic [AHB_DW-1:0] pwdata_q, hrdata_q;
  logic [3:0]        pstrb_q;
  logic [2:0]        pprot_q;
`ifdef AHB_APB_BRIDGE_PSLVERR_EN
  logic              hresp_d, hresp_q;
`endif
  logic              unused_ok;

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    accept_c    = hreadyout_q & bus.hready & bus.hsel & bus.htrans[1];
    done_c      = 1'b0;
    err_c       = 1'b0;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    hreadyout_d = 1'b1;
`ifdef AHB_APB_BRIDGE_PSLVERR_EN
    hresp_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE:   if (accept_c) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.pready) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
`ifdef AHB_APB_BRIDGE_PSLVERR_EN
          if (bus.pslverr) begin
            err_c   = 1'b1;
            state_d = ST_ERR1;
          end
`endif
        end
      end
`ifdef AHB_APB_BRIDGE_PSLVERR_EN
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = accept_c ? ST_SETUP : ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_SETUP: begin
        psel_d      = 1'b1;
        hreadyout_d = 1'b0;
      end
      ST_ACCESS: begin
        psel_d      = 1'b1;
        penable_d   = 1'b1;
        hreadyout_d = 1'b0;
      end
`ifdef AHB_APB_BRIDGE_PSLVERR_EN
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      ST_ERR2: hresp_d = 1'b1;
`endif
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Registered bus outputs, transfer attributes and captured read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= 4'h0;
      pprot_q     <= 3'h0;
      hrdata_q    <= '0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      hreadyout_q <= hreadyout_d;
      if (state_d == ST_SETUP) begin
        paddr_q  <= bus.haddr[APB_AW-1:0];
        pwrite_q <= bus.hwrite;
        pstrb_q  <= apb_strb(bus.hsize, bus.haddr[1:0], bus.hwrite);
        pprot_q  <= {~bus.hprot[0], 1'b0, bus.hprot[1]};
      end
      if (state_q == ST_SETUP) pwdata_q <= bus.hwdata;
      if (done_c && !err_c && !pwrite_q) hrdata_q <= bus.prdata;
    end
  end

`ifdef AHB_APB_BRIDGE_PSLVERR_EN
  // Two-cycle error response flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hresp_q <= 1'b0;
    else      hresp_q <= hresp_d;
  end

  assign bus.hresp = hresp_q;
  assign unused_ok = ^{bus.hburst, bus.hmastlock, bus.hprot[3:2], bus.haddr[AHB_AW-1:APB_AW]};
`else
  assign bus.hresp = 1'b0;
  assign unused_ok = ^{bus.hburst, bus.hmastlock, bus.hprot[3:2], bus.haddr[AHB_AW-1:APB_AW],
                       bus.pslverr};
`endif

  // HWDATA is only valid from SETUP onward, so it is forwarded then and held after.
  assign bus.pwdata    = (state_q == ST_SETUP) ? bus.hwdata : pwdata_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.pprot     = pprot_q;
  assign bus.hreadyout = hreadyout_q;
  assign bus.hrdata    = hrdata_q;

endmodule
